// File: rtl/agu_pkg.sv
// Shared types and helpers for the address-generation pipeline.
// Displacement length encoding, scale type, sign-extension and canonical check.
package agu_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        DISP_NONE,
        DISP_8,
        DISP_16,
        DISP_32
    } disp_len_t;

    typedef logic [1:0] scale_t;

    // Sign-extend the significant low bytes of a raw displacement.
    function automatic logic [MAX_W-1:0] sext_disp(
        input logic [31:0] disp,
        input disp_len_t   len
    );
        logic [MAX_W-1:0] r;
        r = '0;
        unique case (len)
            DISP_8:  r = {{(MAX_W-8){disp[7]}}, disp[7:0]};
            DISP_16: r = {{(MAX_W-16){disp[15]}}, disp[15:0]};
            DISP_32: r = {{(MAX_W-32){disp[31]}}, disp};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Bits [addr_w-1:va_w-1] must all equal the top implemented bit.
    function automatic logic is_canonical(
        input logic [MAX_W-1:0] addr,
        input int               addr_w,
        input int               va_w
    );
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= va_w && i < addr_w && addr[i] != addr[va_w-1])
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/agu_addr_sum.sv
// One-slot effective-address adder with 32-bit truncation and canonical check.
// Ports: mask/addr32 controls, base/scaled/disp operands in; addr/fault out.
module agu_addr_sum
    import agu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int VA_W   = 48
) (
    input  logic              mask,
    input  logic              addr32,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] scaled,
    input  logic [ADDR_W-1:0] disp,
    output logic [ADDR_W-1:0] addr,
    output logic              fault
);

    logic [ADDR_W-1:0] sum;
    logic [MAX_W-1:0]  wide;

    assign sum = base + scaled + disp;

    always_comb begin
        wide = '0;
        wide[ADDR_W-1:0] = sum;
    end

    always_comb begin
        addr  = '0;
        fault = 1'b0;
        if (mask) begin
            addr = sum;
            if (addr32) begin
                for (int b = 32; b < ADDR_W; b++)
                    addr[b] = 1'b0;
            end else begin
                fault = !is_canonical(wide, ADDR_W, VA_W);
            end
        end
    end

endmodule

// File: rtl/agu_pipe.sv
// Two-stage elastic address-generation pipeline (operand scale / add+check).
// Ports: clk, async active-low reset, flush; in_* valid/ready request; out_* result.
module agu_pipe
    import agu_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int VA_W    = 48,
    parameter int NUM_OPS = 3,
    parameter int TAG_W   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_OPS-1:0]              in_mem_mask,
    input  logic [NUM_OPS-1:0][ADDR_W-1:0]  in_base,
    input  logic [NUM_OPS-1:0][ADDR_W-1:0]  in_index,
    input  logic [NUM_OPS-1:0]              in_index_valid,
    input  scale_t [NUM_OPS-1:0]            in_scale,
    input  logic [31:0]                     in_disp,
    input  logic [1:0]                      in_disp_len,
    input  logic                            in_addr32,
    input  logic [ADDR_W-1:0]               in_rip,
    input  logic [TAG_W-1:0]                in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_OPS-1:0][ADDR_W-1:0]  out_addr,
    output logic [NUM_OPS-1:0]              out_mem_mask,
    output logic [NUM_OPS-1:0]              out_fault,
    output logic [ADDR_W-1:0]               out_rip,
    output logic [TAG_W-1:0]                out_tag
);

    logic                           s1_valid;
    logic                           s2_valid;
    logic [NUM_OPS-1:0][ADDR_W-1:0] s1_base;
    logic [NUM_OPS-1:0][ADDR_W-1:0] s1_scaled;
    logic [ADDR_W-1:0]              s1_disp;
    logic [NUM_OPS-1:0]             s1_mask;
    logic                           s1_addr32;
    logic [ADDR_W-1:0]              s1_rip;
    logic [TAG_W-1:0]               s1_tag;

    logic [NUM_OPS-1:0][ADDR_W-1:0] scaled;
    logic [MAX_W-1:0]               disp_ext;
    logic [NUM_OPS-1:0][ADDR_W-1:0] sum_addr;
    logic [NUM_OPS-1:0]             sum_fault;
    logic                           accept;
    logic                           s2_load;

    // S2 frees up when empty or when its result is taken this cycle.
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    assign disp_ext = sext_disp(in_disp, disp_len_t'(in_disp_len));

    always_comb begin
        scaled = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (in_index_valid[i])
                scaled[i] = in_index[i] << in_scale[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept)
                s1_valid <= 1'b1;
            else if (s2_load)
                s1_valid <= 1'b0;
            if (s2_load)
                s2_valid <= 1'b1;
            else if (out_ready)
                s2_valid <= 1'b0;
        end
    end

    // Data may load under flush; the cleared valid makes it harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_base   <= '0;
            s1_scaled <= '0;
            s1_disp   <= '0;
            s1_mask   <= '0;
            s1_addr32 <= 1'b0;
            s1_rip    <= '0;
            s1_tag    <= '0;
        end else if (accept) begin
            s1_base   <= in_base;
            s1_scaled <= scaled;
            s1_disp   <= disp_ext[ADDR_W-1:0];
            s1_mask   <= in_mem_mask;
            s1_addr32 <= in_addr32;
            s1_rip    <= in_rip;
            s1_tag    <= in_tag;
        end
    end

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_slot
        agu_addr_sum #(
            .ADDR_W (ADDR_W),
            .VA_W   (VA_W)
        ) u_sum (
            .mask   (s1_mask[g]),
            .addr32 (s1_addr32),
            .base   (s1_base[g]),
            .scaled (s1_scaled[g]),
            .disp   (s1_disp),
            .addr   (sum_addr[g]),
            .fault  (sum_fault[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_addr     <= '0;
            out_fault    <= '0;
            out_mem_mask <= '0;
            out_rip      <= '0;
            out_tag      <= '0;
        end else if (s2_load) begin
            out_addr     <= sum_addr;
            out_fault    <= sum_fault;
            out_mem_mask <= s1_mask;
            out_rip      <= s1_rip;
            out_tag      <= s1_tag;
        end
    end

endmodule

// File: tb/tb_agu_pipe.sv
// Self-checking bench for agu_pipe: queue-based reference model plus
// directed vectors with hand-computed expectations.
module tb_agu_pipe;

    localparam int ADDR_W  = 64;
    localparam int VA_W    = 48;
    localparam int NUM_OPS = 3;
    localparam int TAG_W   = 16;

    typedef logic [255:0] w_t;

    typedef struct packed {
        logic [2:0]       mask;
        logic [2:0][63:0] base;
        logic [2:0][63:0] index;
        logic [2:0]       iv;
        logic [2:0][1:0]  scale;
        logic [31:0]      disp;
        logic [1:0]       len;
        logic             addr32;
        logic [63:0]      rip;
        logic [15:0]      tag;
    } req_t;

    typedef struct packed {
        logic [2:0][63:0] addr;
        logic [2:0]       fault;
        logic [2:0]       mask;
        logic [63:0]      rip;
        logic [15:0]      tag;
    } res_t;

    logic                           clk;
    logic                           reset;
    logic                           flush;
    logic                           in_valid;
    logic                           in_ready;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_OPS-1:0][ADDR_W-1:0] out_addr;
    logic [NUM_OPS-1:0]             out_mem_mask;
    logic [NUM_OPS-1:0]             out_fault;
    logic [ADDR_W-1:0]              out_rip;
    logic [TAG_W-1:0]               out_tag;

    req_t cur;
    res_t q[$];
    int   nchecks;
    int   nerrors;
    int   npop;

    logic [2:0][63:0] got_addr;
    logic [2:0]       got_fault;

    agu_pipe #(
        .ADDR_W  (ADDR_W),
        .VA_W    (VA_W),
        .NUM_OPS (NUM_OPS),
        .TAG_W   (TAG_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mem_mask    (cur.mask),
        .in_base        (cur.base),
        .in_index       (cur.index),
        .in_index_valid (cur.iv),
        .in_scale       (cur.scale),
        .in_disp        (cur.disp),
        .in_disp_len    (cur.len),
        .in_addr32      (cur.addr32),
        .in_rip         (cur.rip),
        .in_tag         (cur.tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_mem_mask   (out_mem_mask),
        .out_fault      (out_fault),
        .out_rip        (out_rip),
        .out_tag        (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input w_t act, input w_t exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: effective address from plain 64-bit arithmetic.
    function automatic res_t model(input req_t r);
        res_t        o;
        logic [63:0] d;
        logic [63:0] s;
        logic [63:0] lim;
        o = '0;
        lim = 64'd1 << (VA_W - 1);
        case (r.len)
            2'd1:    d = longint'($signed(r.disp[7:0]));
            2'd2:    d = longint'($signed(r.disp[15:0]));
            2'd3:    d = longint'($signed(r.disp));
            default: d = 64'd0;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (r.mask[i]) begin
                s = r.base[i] + d;
                if (r.iv[i])
                    s = s + r.index[i] * (64'd1 << r.scale[i]);
                if (r.addr32) begin
                    o.addr[i] = {32'd0, s[31:0]};
                end else begin
                    o.addr[i]  = s;
                    o.fault[i] = !(s < lim || s >= -lim);
                end
            end
        end
        o.mask = r.mask;
        o.rip  = r.rip;
        o.tag  = r.tag;
        return o;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL spurious_out: out_valid=1 tag %0h, expected no result", out_tag);
                end else begin
                    chk("cmp_addr", w_t'(out_addr), w_t'(q[0].addr));
                    chk("cmp_fault", w_t'(out_fault), w_t'(q[0].fault));
                    chk("cmp_mask", w_t'(out_mem_mask), w_t'(q[0].mask));
                    chk("cmp_rip_tag", w_t'({out_rip, out_tag}), w_t'({q[0].rip, q[0].tag}));
                    if (out_ready) begin
                        void'(q.pop_front());
                        npop++;
                    end
                end
            end
            if (flush)
                q.delete();
            if (in_valid && in_ready && !flush)
                q.push_back(model(cur));
        end
    end

    task automatic send(input req_t r);
        int n;
        n = 0;
        cur = r;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", w_t'(in_ready), w_t'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic one(input req_t r);
        int n;
        send(r);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("one_valid", w_t'(out_valid), w_t'(1));
        got_addr  = out_addr;
        got_fault = out_fault;
        @(posedge clk);
        #1;
    endtask

    function automatic req_t mk(input int i);
        req_t r;
        r = '0;
        r.mask = (i % 2 == 1) ? 3'b101 : 3'b111;
        for (int k = 0; k < 3; k++) begin
            r.base[k]  = 64'h1000_0000 * (k + 1) + 64'(i) * 64'h100;
            r.index[k] = 64'(i + k + 1);
            r.scale[k] = 2'((i + k) % 4);
        end
        r.iv     = 3'b011 ^ 3'(i);
        r.disp   = 32'hFFFF_FF80 + 32'(i * 3);
        r.len    = 2'(i % 4);
        r.addr32 = (i == 4);
        if (i == 5)
            r.base[2] = 64'hFFFF_7000_0000_0000;
        r.rip = 64'h7000 + 64'(i);
        r.tag = 16'h100 + 16'(i);
        return r;
    endfunction

    function automatic req_t req_a();
        req_t r;
        r = '0;
        r.mask     = 3'b001;
        r.base[0]  = 64'h1000;
        r.index[0] = 64'h10;
        r.iv       = 3'b001;
        r.scale[0] = 2'd3;
        r.disp     = 32'hF0;
        r.len      = 2'd1;
        r.rip      = 64'h40_0000;
        r.tag      = 16'hA001;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        req_t r;
        int   npop0;
        int   vcnt;
        int   n;
        nchecks   = 0;
        nerrors   = 0;
        npop      = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cur       = '0;
        #12;
        chk("rst_out_valid", w_t'(out_valid), w_t'(0));
        chk("rst_in_ready", w_t'(in_ready), w_t'(1));
        chk("rst_out_addr", w_t'(out_addr), w_t'(0));
        chk("rst_out_side", w_t'({out_fault, out_mem_mask, out_rip, out_tag}), w_t'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Slot 0 scaled index with negative 8-bit displacement; latency.
        cur = req_a();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_s1_only", w_t'(out_valid), w_t'(0));
        @(negedge clk);
        chk("lat_valid", w_t'(out_valid), w_t'(1));
        chk("a_addr0", w_t'(out_addr[0]), w_t'(64'h1070));
        chk("a_fault", w_t'(out_fault), w_t'(0));
        chk("a_tag", w_t'(out_tag), w_t'(16'hA001));
        @(posedge clk);
        #1;

        // 32-bit truncation versus full-width carry.
        r = '0;
        r.mask    = 3'b001;
        r.base[0] = 64'hFFFF_FFFF;
        r.disp    = 32'h2;
        r.len     = 2'd3;
        r.addr32  = 1'b1;
        one(r);
        chk("a32_addr", w_t'(got_addr[0]), w_t'(64'h1));
        chk("a32_fault", w_t'(got_fault), w_t'(0));
        r.addr32 = 1'b0;
        one(r);
        chk("a64_addr", w_t'(got_addr[0]), w_t'(64'h1_0000_0001));
        chk("a64_fault", w_t'(got_fault), w_t'(0));

        // Non-canonical on masked slot; unmasked slot reads 0.
        r = '0;
        r.mask    = 3'b001;
        r.base[0] = 64'h0000_8000_0000_0000;
        r.base[1] = 64'h0000_8000_0000_0000;
        one(r);
        chk("nc_fault", w_t'(got_fault), w_t'(3'b001));
        chk("nc_addr0", w_t'(got_addr[0]), w_t'(64'h0000_8000_0000_0000));
        chk("nc_addr1", w_t'(got_addr[1]), w_t'(0));

        // Six back-to-back requests with a consumer stall.
        out_ready = 1'b0;
        npop0 = npop;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(mk(i));
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready", w_t'(in_ready), w_t'(0));
                chk("bp_out_valid", w_t'(out_valid), w_t'(1));
                repeat (2) @(negedge clk);
                chk("bp_hold_tag", w_t'(out_tag), w_t'(16'h100));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("stream_count", w_t'(npop - npop0), w_t'(6));
        chk("stream_drained", w_t'(q.size()), w_t'(0));
        @(posedge clk);
        #1;

        // Flush with both stages full and a third request waiting.
        out_ready = 1'b0;
        npop0 = npop;
        send(mk(0));
        send(mk(1));
        cur = mk(2);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", w_t'(in_ready), w_t'(0));
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", w_t'(out_valid), w_t'(0));
        vcnt = 0;
        repeat (4) begin
            @(negedge clk);
            vcnt += int'(out_valid);
        end
        chk("flush_no_result", w_t'(vcnt + npop - npop0), w_t'(0));

        // Flush overrides an accept into an empty pipe.
        @(posedge clk);
        #1;
        cur = mk(3);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_acc_ready", w_t'(in_ready), w_t'(1));
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        vcnt = 0;
        repeat (4) begin
            @(negedge clk);
            vcnt += int'(out_valid);
        end
        chk("flush_acc_drop", w_t'(vcnt), w_t'(0));

        // Reset mid-stream with both stages occupied.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(mk(4));
        send(mk(5));
        reset = 1'b0;
        #1;
        chk("mrst_out_valid", w_t'(out_valid), w_t'(0));
        chk("mrst_out_addr", w_t'(out_addr), w_t'(0));
        chk("mrst_out_side", w_t'({out_fault, out_mem_mask, out_rip, out_tag}), w_t'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        send(req_a());
        @(negedge clk);
        chk("prst_s1_only", w_t'(out_valid), w_t'(0));
        @(negedge clk);
        chk("prst_valid", w_t'(out_valid), w_t'(1));
        chk("prst_addr0", w_t'(out_addr[0]), w_t'(64'h1070));
        chk("prst_tag", w_t'(out_tag), w_t'(16'hA001));
        repeat (3) @(negedge clk);
        chk("end_drained", w_t'(q.size()), w_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
